pe_traffic_node: RTL and testbench

//  Synthesizable traffic generator/sink PE for the torus NoC. It replaces the behavioural testbench PE.

---
 rtl/pe_traffic_node.sv | 170 +++++++++++++++++
 tb/tb_pe_traffic_node.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_traffic_node.sv
// pe_traffic_node: synthesizable traffic generator / sink for one torus NoC local port.
// Injects PktLimit packets at a programmable rate to pattern-selected destinations and
// sinks every arriving flit, keeping tx/rx counts, summed latency and maximum latency.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         level; packet generation allowed while high
//   i_data          incoming flit, i_data[31:0] is the sender's timestamp
//   i_data_valid    incoming flit valid (always accepted)
//   o_data_ready    sink ready, constant 1
//   o_data          outgoing flit {1'b1, 1'b1, dest, 1'b0, timestamp[31:0]}
//   o_data_valid    outgoing flit valid
//   i_data_ready    switch accepts the outgoing flit
//   o_tx_count      packets accepted by the switch (saturating)
//   o_rx_count      packets received (saturating)
//   o_lat_sum       sum of receive latencies (saturating)
//   o_lat_max       maximum receive latency
//   o_tx_done       high once PktLimit packets are accepted
module pe_traffic_node #(
  parameter int unsigned Address      = 0,
  parameter int unsigned AddressWidth = 5,
  parameter int unsigned NumPE        = 32,
  parameter int unsigned PktLimit     = 20,
  parameter int unsigned Pattern      = 0,
  parameter int unsigned InjRate      = 256,
  parameter logic [15:0] Seed         = 16'hACE1,
  parameter int unsigned DataWidth    = AddressWidth + 35
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [DataWidth-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [31:0]          o_tx_count,
  output logic [31:0]          o_rx_count,
  output logic [47:0]          o_lat_sum,
  output logic [31:0]          o_lat_max,
  output logic                 o_tx_done
);

  typedef enum logic [1:0] {StIdle, StGap, StSend, StDone} state_e;

  localparam logic [15:0] SeedMix  = Seed ^ 16'(Address);
  localparam logic [15:0] SeedInit = (SeedMix == 16'h0000) ? 16'h0001 : SeedMix;

  // Destination for every pattern except RANDOM depends only on Address, so it is a constant.
  function automatic int unsigned calc_static_dest();
    logic [AddressWidth-1:0] a;
    logic [AddressWidth-1:0] d;
    int unsigned             r;
    a = AddressWidth'(Address);
    d = a;
    r = 0;
    case (Pattern)
      1: d = ~a;
      2: for (int j = 0; j < int'(AddressWidth); j++) d[j] = a[int'(AddressWidth) - 1 - j];
      3: for (int j = 0; j < int'(AddressWidth); j++) d[j] = a[(j + 1) % int'(AddressWidth)];
      4: for (int j = 0; j < int'(AddressWidth); j++) begin
        d[j] = a[(j + int'(AddressWidth) / 2) % int'(AddressWidth)];
      end
      default: d = a;
    endcase
    if (Pattern == 5) begin
      r = (Address + (NumPE + 1) / 2) % NumPE;
    end else if (Pattern == 6) begin
      r = (Address + 1) % NumPE;
    end else begin
      r = 32'(d) % NumPE;
    end
    return r;
  endfunction

  localparam int unsigned StaticDest = calc_static_dest();

  state_e                 state_q, state_d;
  logic [31:0]            ts_q;
  logic [15:0]            lfsr_q, lfsr_step;
  logic [DataWidth-1:0]   data_q;
  logic [31:0]            tx_count_q, rx_count_q, lat_max_q;
  logic [47:0]            lat_sum_q;

  logic                   lfsr_adv, load_flit, tx_inc, rate_hit;
  int unsigned            rnd_dest;
  logic [AddressWidth-1:0] dest;
  logic [31:0]            latency;
  logic [48:0]            sum_wide;
  logic                   unused_data;

  // Galois LFSR, taps 0xB400.
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign rate_hit  = 32'(lfsr_q[7:0]) < InjRate;

  always_comb begin
    rnd_dest = 32'(lfsr_q) % NumPE;
    if (rnd_dest == Address) rnd_dest = (rnd_dest + 1) % NumPE;
    dest = (Pattern == 0) ? AddressWidth'(rnd_dest) : AddressWidth'(StaticDest);
  end

  always_comb begin
    state_d   = state_q;
    lfsr_adv  = 1'b0;
    load_flit = 1'b0;
    tx_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = (PktLimit > 0) ? StGap : StDone;
      end
      StGap: begin
        lfsr_adv = 1'b1;
        if (i_start && rate_hit) begin
          load_flit = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        // Valid is held until accepted, independent of i_start.
        if (i_data_ready) begin
          tx_inc   = 1'b1;
          lfsr_adv = 1'b1;
          state_d  = ((33'(tx_count_q) + 33'd1) == 33'(PktLimit)) ? StDone : StGap;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Latency arithmetic is modulo 2^32 so timestamp wrap is handled naturally.
  assign latency     = ts_q - i_data[31:0];
  assign sum_wide    = {1'b0, lat_sum_q} + 49'(latency);
  assign unused_data = ^i_data[DataWidth-1:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ts_q       <= 32'd0;
      lfsr_q     <= SeedInit;
      data_q     <= '0;
      tx_count_q <= 32'd0;
      rx_count_q <= 32'd0;
      lat_sum_q  <= 48'd0;
      lat_max_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 32'd1;
      if (lfsr_adv) lfsr_q <= lfsr_step;
      if (load_flit) data_q <= DataWidth'({1'b1, 1'b1, dest, 1'b0, ts_q});
      if (tx_inc && (tx_count_q != '1)) tx_count_q <= tx_count_q + 32'd1;
      if (i_data_valid) begin
        if (rx_count_q != '1) rx_count_q <= rx_count_q + 32'd1;
        lat_sum_q <= sum_wide[48] ? '1 : sum_wide[47:0];
        if (latency > lat_max_q) lat_max_q <= latency;
      end
    end
  end

  assign o_data_ready = 1'b1;
  assign o_data       = data_q;
  assign o_data_valid = (state_q == StSend);
  assign o_tx_done    = (state_q == StDone);
  assign o_tx_count   = tx_count_q;
  assign o_rx_count   = rx_count_q;
  assign o_lat_sum    = lat_sum_q;
  assign o_lat_max    = lat_max_q;

endmodule

// File: tb/tb_pe_traffic_node.sv
// Testbench for pe_traffic_node: a NEIGHBOUR node (Address 3, 4 packets) exercises cadence,
// stalls, sink statistics, reset in SEND and timestamp wrap; a RANDOM node (Address 5,
// rate 160/256) is checked against a packet-level destination sequence model.
module tb_pe_traffic_node;

  localparam int unsigned DW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, in_valid_a, in_ready_a, out_ready_a, valid_a, done_a;
  logic [DW-1:0] in_data_a, data_a;
  logic [31:0]   tx_a, rx_a, max_a;
  logic [47:0]   sum_a;

  logic          rst_b, start_b, in_valid_b, in_ready_b, out_ready_b, valid_b, done_b;
  logic [DW-1:0] in_data_b, data_b;
  logic [31:0]   tx_b, rx_b, max_b;
  logic [47:0]   sum_b;

  pe_traffic_node #(
    .Address(3), .AddressWidth(5), .NumPE(32), .PktLimit(4), .Pattern(6), .InjRate(256),
    .Seed(16'hACE1), .DataWidth(DW)
  ) dut_a (
    .clk(clk), .rst(rst_a), .i_start(start_a), .i_data(in_data_a), .i_data_valid(in_valid_a),
    .o_data_ready(out_ready_a), .o_data(data_a), .o_data_valid(valid_a),
    .i_data_ready(in_ready_a), .o_tx_count(tx_a), .o_rx_count(rx_a), .o_lat_sum(sum_a),
    .o_lat_max(max_a), .o_tx_done(done_a)
  );

  pe_traffic_node #(
    .Address(5), .AddressWidth(5), .NumPE(32), .PktLimit(1000), .Pattern(0), .InjRate(160),
    .Seed(16'hACE1), .DataWidth(DW)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_start(start_b), .i_data(in_data_b), .i_data_valid(in_valid_b),
    .o_data_ready(out_ready_b), .o_data(data_b), .o_data_valid(valid_b),
    .i_data_ready(in_ready_b), .o_tx_count(tx_b), .o_rx_count(rx_b), .o_lat_sum(sum_b),
    .o_lat_max(max_b), .o_tx_done(done_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] now_a = 0;
  logic [31:0] now_b = 0;
  logic [15:0] m_lfsr;
  int unsigned first_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge. now_x mirrors each node's timestamp.
  task automatic tick();
    logic ra, rb;
    ra = rst_a;
    rb = rst_b;
    @(posedge clk);
    #1;
    if (!ra) now_a++;
    if (!rb) now_b++;
  endtask

  function automatic logic [DW-1:0] flit(input int unsigned dest, input logic [31:0] ts);
    logic [4:0] d;
    d = dest[4:0];
    return {1'b1, 1'b1, d, 1'b0, ts};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic model_reset_b();
    m_lfsr = 16'hACE1 ^ 16'd5;
    if (m_lfsr == 16'd0) m_lfsr = 16'd1;
  endtask

  // Packet-level view: skip rate misses, pick dest, one step for the injecting GAP cycle,
  // one step for the acceptance.
  task automatic model_next_b(output int unsigned d);
    while (int'(m_lfsr[7:0]) >= 160) m_lfsr = lfsr_next(m_lfsr);
    d = int'(m_lfsr) % 32;
    if (d == 5) d = 6;
    m_lfsr = lfsr_next(lfsr_next(m_lfsr));
  endtask

  task automatic run_b(input int n, input bit compare_first);
    int            accepted;
    int            cycles;
    bit            stalled;
    logic [DW-1:0] held;
    int unsigned   d;
    logic [4:0]    got;
    accepted = 0;
    cycles   = 0;
    stalled  = 0;
    held     = '0;
    start_b  = 1;
    while (accepted < n && cycles < 20000) begin
      tick();
      cycles++;
      if (valid_b) begin
        if (stalled) check("b_hold_flit", data_b, held);
        in_ready_b = ($urandom_range(0, 3) != 0);
        if (in_ready_b) begin
          model_next_b(d);
          got = data_b[37:33];
          check("b_dest", got, d[4:0]);
          check("b_dest_not_self", (got != 5'd5), 1);
          check("b_dest_range", (int'(got) < 32), 1);
          if (accepted == 0) check("b_flag_bits", {data_b[39:38], data_b[32]}, 3'b110);
          if (compare_first) check("b_repeat", got, first_q[accepted]);
          else first_q.push_back(int'(got));
          accepted++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = data_b;
        end
      end else begin
        if (stalled) check("b_valid_withdrawn", valid_b, 1);
        stalled = 0;
      end
    end
    check("b_packets_within_budget", accepted, n);
  endtask

  logic [DW-1:0] exp_flit;
  int unsigned   rx_m, lat_m;
  logic [47:0]   sum_m;
  logic [31:0]   max_m;
  bit            v;

  initial begin
    rst_a = 1; start_a = 0; in_valid_a = 0; in_data_a = '0; in_ready_a = 0;
    rst_b = 1; start_b = 0; in_valid_b = 0; in_data_b = '0; in_ready_b = 0;
    tick();
    tick();
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_done", done_a, 0);
    check("rst_tx", tx_a, 0);
    check("rst_rx", rx_a, 0);
    check("rst_sum", sum_a, 0);
    check("rst_max", max_a, 0);
    check("sink_ready", out_ready_a, 1);
    rst_a = 0; rst_b = 0; now_a = 0; now_b = 0;

    // Four NEIGHBOUR flits in GAP/SEND cadence, third one stalled for 10 cycles.
    start_a = 1; in_ready_a = 1;
    for (int p = 0; p < 4; p++) begin
      tick();
      check("gap_valid", valid_a, 0);
      check("gap_done", done_a, 0);
      check("gap_tx_count", tx_a, p);
      tick();
      check("send_valid", valid_a, 1);
      exp_flit = flit((3 + 1) % 32, now_a - 1);
      check("send_flit", data_a, exp_flit);
      if (p == 2) begin
        in_ready_a = 0;
        for (int s = 0; s < 10; s++) begin
          tick();
          check("stall_valid", valid_a, 1);
          check("stall_flit", data_a, exp_flit);
        end
        in_ready_a = 1;
      end
    end
    tick();
    check("done_flag", done_a, 1);
    check("done_valid", valid_a, 0);
    check("done_tx", tx_a, 4);
    start_a = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("done_sticky", done_a, 1);
      check("done_tx_hold", tx_a, 4);
    end

    // Sink: latencies 7 and 3.
    in_valid_a = 1;
    in_data_a  = {8'h00, now_a - 32'd7};
    tick();
    in_data_a  = {8'h00, now_a - 32'd3};
    tick();
    in_valid_a = 0;
    check("sink_rx", rx_a, 2);
    check("sink_sum", sum_a, 10);
    check("sink_max", max_a, 7);

    // Random sink traffic against running statistics.
    rx_m = 2; sum_m = 10; max_m = 7;
    for (int i = 0; i < 60; i++) begin
      v          = 1'($urandom_range(0, 1));
      lat_m      = (i == 30) ? 32'h8000_0123 : $urandom_range(0, 2000);
      in_valid_a = v;
      in_data_a  = {8'($urandom), now_a - 32'(lat_m)};
      tick();
      if (v) begin
        rx_m++;
        sum_m += 48'(lat_m);
        if (32'(lat_m) > max_m) max_m = 32'(lat_m);
      end
      check("rand_rx", rx_a, rx_m);
      check("rand_sum", sum_a, sum_m);
      check("rand_max", max_a, max_m);
    end
    in_valid_a = 0;

    // Reset in SEND drops the pending flit.
    rst_a = 1; #1; rst_a = 0; now_a = 0;
    start_a = 1; in_ready_a = 0;
    tick();
    tick();
    check("pre_rst_send_valid", valid_a, 1);
    start_a = 0;
    rst_a   = 1;
    #1;
    check("rst_send_valid", valid_a, 0);
    check("rst_send_data", data_a, 0);
    check("rst_send_rx", rx_a, 0);
    tick();
    check("rst_held_valid", valid_a, 0);
    check("rst_held_done", done_a, 0);
    rst_a = 0; now_a = 0;

    // Timestamp wrap: payload 0xFFFF_FFFE seen at counter 1.
    tick();
    in_valid_a = 1;
    in_data_a  = {8'h00, 32'hFFFF_FFFE};
    tick();
    in_valid_a = 0;
    check("wrap_rx", rx_a, 1);
    check("wrap_sum", sum_a, 3);
    check("wrap_max", max_a, 3);

    start_a = 1; in_ready_a = 1;
    tick();
    check("restart_gap_valid", valid_a, 0);
    tick();
    check("restart_valid", valid_a, 1);
    check("restart_tx", tx_a, 0);
    check("restart_flit", data_a, flit(4, now_a - 1));
    tick();
    check("restart_tx_after", tx_a, 1);

    // RANDOM node: full run, then rerun after reset must reproduce the sequence.
    model_reset_b();
    run_b(1000, 1'b0);
    tick();
    check("b_done", done_b, 1);
    check("b_tx", tx_b, 1000);
    check("b_done_valid", valid_b, 0);
    start_b = 0;
    rst_b = 1; #1; rst_b = 0; now_b = 0;
    check("b_rst_tx", tx_b, 0);
    model_reset_b();
    run_b(50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
